mips_cpu_lsu: RTL and testbench
===============================

Name: mips_cpu_lsu

Overview:
- Load/store unit between the CPU datapath's memory stage and the word-wide Avalon-style data RAM.
- Converts one CPU load/store request (byte, half, word, LWL/LWR) into a single aligned word transaction with byteenable.
- Honours waitrequest and the RAM's one-cycle registered read data.
- Extracts, extends or merges the load result and returns it with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, width of CPU and bus addresses.
- MISALIGN_CHECK, 1, when 1, misaligned half/word accesses are trapped without a bus transaction; when 0, addr[1:0] is ignored for LH/LHU/SH/LW/SW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
- req_op  in  4  lsu_op_t operation code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rt  in  32  current rt value, used for LWL/LWR merge.
- resp_valid  out  1  one-cycle pulse: result ready.
- resp_rdata  out  32  load result; 0 for stores and on error.
- resp_misaligned  out  1  valid with resp_valid; access trapped.
- avm_address  out  32  word-aligned address {req_addr[31:2],2'b00}.
- avm_read  out  1  bus read request.
- avm_write  out  1  bus write request.
- avm_waitrequest  in  1  slave stall; hold request while high.
- avm_writedata  out  32  lane-aligned store data.
- avm_byteenable  out  4  active byte lanes; lane k = bits [8k+7:8k] = byte offset k (little-endian).
- avm_readdata  in  32  registered read data, valid the cycle after read is accepted.

Behaviour:
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_misaligned=0; avm_read=0; avm_write=0; avm_address=0; avm_writedata=0; avm_byteenable=0. State is IDLE.
- Reset is asynchronous. Asserting it mid-transaction drops avm_read/avm_write immediately and discards the pending response.
- All outputs are registered. Request fields are captured on acceptance.
- FSM states: IDLE, BUS, RDATA, RESP.
- IDLE, request accepted:
  - if misaligned (and MISALIGN_CHECK=1) -> RESP with resp_misaligned=1, no bus cycle;
  - else drive avm_* -> BUS.
- BUS:
  - hold avm_address, avm_read/avm_write, avm_writedata and avm_byteenable stable while avm_waitrequest=1;
  - on the first cycle with avm_waitrequest=0: drop avm_read/avm_write; store -> RESP; load -> RDATA.
- RDATA: sample avm_readdata, form result -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle -> IDLE;
  - req_ready is 0 in all non-IDLE states;
  - req_ready returns to 1 the cycle after RESP.
- Minimum latency, acceptance (cycle 0) to resp_valid:
  - store: cycle 2;
  - load: cycle 3;
  - misaligned: cycle 1;
  - each waitrequest cycle adds 1.
- Byteenable and write data, with k=addr[1:0]:
  - SB: be=1<<k, wdata=req_wdata[7:0] replicated to all lanes.
  - SH: be=k[1]?4'b1100:4'b0011, half replicated to both halves.
  - SW: be=4'hF.
- Load data extraction:
  - LB/LBU: byte lane k, sign- or zero-extended.
  - LH/LHU: half k[1], sign- or zero-extended.
  - LW: full word, be=4'hF.
- LWL: be = lanes 0..k; result = (mem << 8*(3-k)) | (rt & ((1<<8*(3-k))-1)).
- LWR: be = lanes k..3; result = (mem >> 8k) | (rt & ~(32'hFFFFFFFF >> 8k)).
- LWL/LWR are never misaligned.
- Undefined req_op: treated as misaligned error, no bus cycle.
- avm_read and avm_write are never asserted together.
- A word address of 0 is issued like any other; the RAM's halt behaviour is not special-cased here.

Decomposition:
- Package mips_cpu_lsu_pkg holds:
  - lsu_op_t (4-bit enum: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10);
  - lsu_state_t;
  - helper functions is_store(op) and is_misaligned(op,addr).
- One combinational sub-module, mips_cpu_lsu_align, maps (op, k, mem word, rt) to the load result and (op, k, wdata) to {byteenable, writedata}.
- The FSM stays in mips_cpu_lsu.

Test Plan:
- SW addr=0xBFC00010 wdata=0xDEADBEEF, waitrequest=0 -> cycle 1: avm_write=1, be=F, address 0xBFC00010; cycle 2: resp_valid=1, rdata=0.
- SB addr=0xBFC00013 wdata=0x000000A5 -> be=4'b1000, writedata=0xA5A5A5A5. Then LB same address with RAM word 0xA5000000 -> rdata=0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr=0xBFC00022, RAM word 0x8001_1234 -> be=4'b1100, rdata=0xFFFF8001. LH addr=0xBFC00021 -> resp_valid at cycle 1, misaligned=1, avm_read never asserted.
- LWL addr k=1, mem=0x44332211, rt=0xAABBCCDD -> rdata=0x2211CCDD. LWR k=1, same inputs -> rdata=0xAA443322.
- LW with waitrequest held high 3 cycles -> avm_read and address stable throughout; resp_valid at cycle 6; exactly one read accepted.
- rst_n low during BUS of an SW -> avm_write=0 asynchronously, no resp_valid; after release req_ready=1 and the next LW completes normally.

Source files
------------

// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// Operation codes match the encoding the CPU memory stage already produces.
package mips_cpu_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // LWL/LWR exist precisely to handle unaligned words, so they never trap.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
            OP_LW, OP_SW:         mis = |addr_lo;
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Lane steering for the LSU: byteenable/write-data for the request side and
// extract/extend/merge of the returned RAM word for the load side.
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  k_i,
    input  logic [31:0] mem_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] lane_wdata_o
);

    logic [31:0] mem_shr;
    logic [31:0] mem_shl;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] lwl_v;
    logic [31:0] lwr_v;

    // 3-k equals ~k for a 2-bit offset, which keeps the LWL shifts simple.
    always_comb begin
        mem_shr = mem_i >> {k_i, 3'b000};
        mem_shl = mem_i << {~k_i, 3'b000};
        byte_v  = mem_shr[7:0];
        half_v  = k_i[1] ? mem_i[31:16] : mem_i[15:0];
        lwl_v   = mem_shl | (rt_i & ~(32'hFFFF_FFFF << {~k_i, 3'b000}));
        lwr_v   = mem_shr | (rt_i & ~(32'hFFFF_FFFF >> {k_i, 3'b000}));
    end

    always_comb begin
        rdata_o      = 32'd0;
        be_o         = 4'b0000;
        lane_wdata_o = wdata_i;
        case (op_i)
            OP_LB: begin
                be_o    = 4'b0001 << k_i;
                rdata_o = {{24{byte_v[7]}}, byte_v};
            end
            OP_LBU: begin
                be_o    = 4'b0001 << k_i;
                rdata_o = {24'd0, byte_v};
            end
            OP_LH: begin
                be_o    = k_i[1] ? 4'b1100 : 4'b0011;
                rdata_o = {{16{half_v[15]}}, half_v};
            end
            OP_LHU: begin
                be_o    = k_i[1] ? 4'b1100 : 4'b0011;
                rdata_o = {16'd0, half_v};
            end
            OP_LW: begin
                be_o    = 4'hF;
                rdata_o = mem_i;
            end
            OP_LWL: begin
                be_o    = 4'b1111 >> ~k_i;
                rdata_o = lwl_v;
            end
            OP_LWR: begin
                be_o    = 4'b1111 << k_i;
                rdata_o = lwr_v;
            end
            OP_SB: begin
                be_o         = 4'b0001 << k_i;
                lane_wdata_o = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                be_o         = k_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata_o = {2{wdata_i[15:0]}};
            end
            OP_SW: begin
                be_o = 4'hF;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one CPU request becomes one aligned Avalon word transfer,
// with a single-cycle response pulse carrying the formatted load result.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready high
//   BUS   | avm_read/avm_write asserted, waiting for waitrequest low
//   RDATA | RAM registered read data arrives; load result formed
//   RESP  | resp_valid pulse; stores, traps and loads all end here
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [31:0]       req_rt_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_misaligned_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    input  logic              avm_waitrequest_i,
    output logic [31:0]       avm_writedata_o,
    output logic [3:0]        avm_byteenable_o,
    input  logic [31:0]       avm_readdata_i
);

    lsu_state_t        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       rt_q, rt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic [31:0]       avm_wdata_q, avm_wdata_d;
    logic [3:0]        avm_be_q, avm_be_d;

    logic [3:0]  al_op;
    logic [1:0]  al_k;
    logic [31:0] al_rdata;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        accept;
    logic        trap;

    // In IDLE the aligner sees the live request; afterwards the captured one.
    assign al_op = (state_q == ST_IDLE) ? req_op_i : op_q;
    assign al_k  = (state_q == ST_IDLE) ? req_addr_i[1:0] : k_q;

    mips_cpu_lsu_align u_align (
        .op_i         (al_op),
        .k_i          (al_k),
        .mem_i        (avm_readdata_i),
        .rt_i         (rt_q),
        .wdata_i      (req_wdata_i),
        .rdata_o      (al_rdata),
        .be_o         (al_be),
        .lane_wdata_o (al_wdata)
    );

    assign accept = req_valid_i && req_ready_q;
    assign trap   = !is_valid_op(req_op_i) ||
                    (MISALIGN_CHECK && is_misaligned(req_op_i, req_addr_i[1:0]));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        k_d           = k_q;
        rt_d          = rt_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_mis_d    = resp_mis_q;
        avm_address_d = avm_address_q;
        avm_read_d    = avm_read_q;
        avm_write_d   = avm_write_q;
        avm_wdata_d   = avm_wdata_q;
        avm_be_d      = avm_be_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = req_op_i;
                    k_d  = req_addr_i[1:0];
                    rt_d = req_rt_i;
                    if (trap) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_mis_d   = 1'b1;
                    end else begin
                        state_d       = ST_BUS;
                        avm_address_d = {req_addr_i[ADDR_W-1:2], 2'b00};
                        avm_write_d   = is_store(req_op_i);
                        avm_read_d    = !is_store(req_op_i);
                        avm_wdata_d   = al_wdata;
                        avm_be_d      = al_be;
                    end
                end
            end
            ST_BUS: begin
                if (!avm_waitrequest_i) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (avm_write_q) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_mis_d   = 1'b0;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = al_rdata;
                resp_mis_d   = 1'b0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            op_q          <= 4'd0;
            k_q           <= 2'd0;
            rt_q          <= 32'd0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            resp_mis_q    <= 1'b0;
            avm_address_q <= '0;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            avm_wdata_q   <= 32'd0;
            avm_be_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            k_q           <= k_d;
            rt_q          <= rt_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_mis_q    <= resp_mis_d;
            avm_address_q <= avm_address_d;
            avm_read_q    <= avm_read_d;
            avm_write_q   <= avm_write_d;
            avm_wdata_q   <= avm_wdata_d;
            avm_be_q      <= avm_be_d;
        end
    end

    assign req_ready_o       = req_ready_q;
    assign resp_valid_o      = resp_valid_q;
    assign resp_rdata_o      = resp_rdata_q;
    assign resp_misaligned_o = resp_mis_q;
    assign avm_address_o     = avm_address_q;
    assign avm_read_o        = avm_read_q;
    assign avm_write_o       = avm_write_q;
    assign avm_writedata_o   = avm_wdata_q;
    assign avm_byteenable_o  = avm_be_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu with a one-word RAM model that stalls for a
// programmable number of cycles and returns registered read data.
module tb_mips_cpu_lsu;
    import mips_cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_rt = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_mis;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic        avm_waitrequest;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = 32'd0;

    logic [31:0] ram_word = 32'd0;
    int          nw_cfg = 0;
    int          busy_cnt = 0;
    int          rd_count = 0;
    int          wr_count = 0;

    int          n_tests = 0;
    int          n_fail = 0;

    int          r_lat;
    logic [31:0] r_rdata, r_wd, r_adr;
    logic [3:0]  r_be;
    logic        r_mis, r_rd1, r_wr1, r_stable, r_both, r_any_bus;
    int          r_rd_n, r_wr_n;

    always #5 clk = ~clk;

    mips_cpu_lsu #(.ADDR_W(32), .MISALIGN_CHECK(1'b1)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_rt_i          (req_rt),
        .resp_valid_o      (resp_valid),
        .resp_rdata_o      (resp_rdata),
        .resp_misaligned_o (resp_mis),
        .avm_address_o     (avm_address),
        .avm_read_o        (avm_read),
        .avm_write_o       (avm_write),
        .avm_waitrequest_i (avm_waitrequest),
        .avm_writedata_o   (avm_writedata),
        .avm_byteenable_o  (avm_byteenable),
        .avm_readdata_i    (avm_readdata)
    );

    // Stall for nw_cfg cycles of each bus request, then accept it.
    assign avm_waitrequest = (busy_cnt < nw_cfg);

    always @(posedge clk) begin
        if (avm_read || avm_write) busy_cnt <= busy_cnt + 1;
        else                       busy_cnt <= 0;
        if (avm_read && !avm_waitrequest) begin
            avm_readdata <= ram_word;
            rd_count     <= rd_count + 1;
        end
        if (avm_write && !avm_waitrequest) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rt, input logic [31:0] ram, input int nw);
        int rd0;
        int wr0;
        rd0 = rd_count;
        wr0 = wr_count;
        @(negedge clk);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rt    = rt;
        ram_word  = ram;
        nw_cfg    = nw;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 0; r_stable = 1'b1; r_both = 1'b0; r_any_bus = 1'b0;
        r_rdata = 32'hxxxx_xxxx; r_mis = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                r_be = avm_byteenable; r_wd = avm_writedata; r_adr = avm_address;
                r_rd1 = avm_read; r_wr1 = avm_write;
            end else if (avm_read || avm_write) begin
                if (avm_address !== r_adr || avm_byteenable !== r_be || avm_writedata !== r_wd ||
                    avm_read !== r_rd1 || avm_write !== r_wr1) r_stable = 1'b0;
            end
            if (avm_read || avm_write) r_any_bus = 1'b1;
            if (avm_read && avm_write) r_both = 1'b1;
            if (resp_valid) begin
                r_lat = c; r_rdata = resp_rdata; r_mis = resp_mis;
                break;
            end
        end
        chk("resp_seen", 32'(r_lat != 0), 32'd1);
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        chk("rd_wr_exclusive", 32'(r_both), 32'd0);
        r_rd_n = rd_count - rd0;
        r_wr_n = wr_count - wr0;
    endtask

    initial begin
        logic saw_resp;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mis", 32'(resp_mis), 32'd0);
        chk("rst_rd_wr", {30'd0, avm_read, avm_write}, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'd0);
        rst_n = 1'b1;

        run_req(OP_SW, 32'hBFC0_0010, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
        chk("sw_write", 32'(r_wr1), 32'd1);
        chk("sw_read", 32'(r_rd1), 32'd0);
        chk("sw_be", 32'(r_be), 32'hF);
        chk("sw_addr", r_adr, 32'hBFC0_0010);
        chk("sw_wdata", r_wd, 32'hDEAD_BEEF);
        chk("sw_lat", 32'(r_lat), 32'd2);
        chk("sw_rdata", r_rdata, 32'd0);
        chk("sw_mis", 32'(r_mis), 32'd0);
        chk("sw_wr_n", 32'(r_wr_n), 32'd1);

        run_req(OP_SB, 32'hBFC0_0013, 32'h0000_00A5, 32'd0, 32'd0, 0);
        chk("sb_be", 32'(r_be), 32'b1000);
        chk("sb_wdata", r_wd, 32'hA5A5_A5A5);
        chk("sb_addr", r_adr, 32'hBFC0_0010);

        run_req(OP_LB, 32'hBFC0_0013, 32'd0, 32'd0, 32'hA500_0000, 0);
        chk("lb_read", 32'(r_rd1), 32'd1);
        chk("lb_be", 32'(r_be), 32'b1000);
        chk("lb_lat", 32'(r_lat), 32'd3);
        chk("lb_rdata", r_rdata, 32'hFFFF_FFA5);
        run_req(OP_LBU, 32'hBFC0_0013, 32'd0, 32'd0, 32'hA500_0000, 0);
        chk("lbu_rdata", r_rdata, 32'h0000_00A5);

        run_req(OP_LH, 32'hBFC0_0022, 32'd0, 32'd0, 32'h8001_1234, 0);
        chk("lh_be", 32'(r_be), 32'b1100);
        chk("lh_addr", r_adr, 32'hBFC0_0020);
        chk("lh_rdata", r_rdata, 32'hFFFF_8001);
        run_req(OP_LHU, 32'hBFC0_0020, 32'd0, 32'd0, 32'h8001_9234, 0);
        chk("lhu_be", 32'(r_be), 32'b0011);
        chk("lhu_rdata", r_rdata, 32'h0000_9234);

        run_req(OP_LH, 32'hBFC0_0021, 32'd0, 32'd0, 32'h8001_1234, 0);
        chk("lh_mis_lat", 32'(r_lat), 32'd1);
        chk("lh_mis_flag", 32'(r_mis), 32'd1);
        chk("lh_mis_nobus", 32'(r_any_bus), 32'd0);
        chk("lh_mis_rdata", r_rdata, 32'd0);

        run_req(OP_LWL, 32'hBFC0_0041, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("lwl1_be", 32'(r_be), 32'b0011);
        chk("lwl1_rdata", r_rdata, 32'h2211_CCDD);
        run_req(OP_LWR, 32'hBFC0_0041, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("lwr1_be", 32'(r_be), 32'b1110);
        chk("lwr1_rdata", r_rdata, 32'hAA44_3322);
        run_req(OP_LWL, 32'hBFC0_0040, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("lwl0_be", 32'(r_be), 32'b0001);
        chk("lwl0_rdata", r_rdata, 32'h11BB_CCDD);
        run_req(OP_LWR, 32'hBFC0_0043, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("lwr3_be", 32'(r_be), 32'b1000);
        chk("lwr3_rdata", r_rdata, 32'hAABB_CC44);

        run_req(OP_LW, 32'hBFC0_0100, 32'd0, 32'd0, 32'h1234_5678, 3);
        chk("lw_wait_lat", 32'(r_lat), 32'd6);
        chk("lw_wait_stable", 32'(r_stable), 32'd1);
        chk("lw_wait_rd_n", 32'(r_rd_n), 32'd1);
        chk("lw_wait_rdata", r_rdata, 32'h1234_5678);

        run_req(OP_SH, 32'hBFC0_0006, 32'h0000_BEEF, 32'd0, 32'd0, 1);
        chk("sh_be", 32'(r_be), 32'b1100);
        chk("sh_wdata", r_wd, 32'hBEEF_BEEF);
        chk("sh_lat", 32'(r_lat), 32'd3);

        run_req(4'd7, 32'hBFC0_0000, 32'd0, 32'd0, 32'd0, 0);
        chk("undef_mis", 32'(r_mis), 32'd1);
        chk("undef_lat", 32'(r_lat), 32'd1);
        chk("undef_nobus", 32'(r_any_bus), 32'd0);

        run_req(OP_SW, 32'hBFC0_0012, 32'h1111_2222, 32'd0, 32'd0, 0);
        chk("sw_mis_flag", 32'(r_mis), 32'd1);
        chk("sw_mis_wr_n", 32'(r_wr_n), 32'd0);

        @(negedge clk);
        req_op = OP_SW; req_addr = 32'hBFC0_0200; req_wdata = 32'hCAFE_F00D;
        nw_cfg = 5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_bus_write_pre", 32'(avm_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus_write_async", 32'(avm_write), 32'd0);
        chk("rst_bus_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        nw_cfg = 0;
        rst_n = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        chk("rst_bus_no_resp", 32'(saw_resp), 32'd0);
        chk("rst_bus_ready_after", 32'(req_ready), 32'd1);
        run_req(OP_LW, 32'hBFC0_0300, 32'd0, 32'd0, 32'h0BAD_F00D, 0);
        chk("post_rst_lw_lat", 32'(r_lat), 32'd3);
        chk("post_rst_lw_rdata", r_rdata, 32'h0BAD_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
